// File: rtl/ghost_chaser_if.sv
// rtl/ghost_chaser_if.sv - ghost_chaser map/position bus (slave = ghost, master = surrounding logic)
interface ghost_chaser_if;
    logic [9:0] pX;
    logic [9:0] pY;
    logic       wall_u;
    logic       wall_r;
    logic       wall_d;
    logic       wall_l;
    logic [9:0] gX;
    logic [9:0] gY;
    logic [9:0] gSize;
    logic [1:0] dir;
    logic       mode;
    logic       move_done;

    modport master (
        output pX, pY, wall_u, wall_r, wall_d, wall_l,
        input  gX, gY, gSize, dir, mode, move_done
    );

    modport slave (
        input  pX, pY, wall_u, wall_r, wall_d, wall_l,
        output gX, gY, gSize, dir, mode, move_done
    );
endinterface

// File: rtl/ghost_chaser.sv
// rtl/ghost_chaser.sv - per-frame ghost movement controller
// Optional chase/scatter mode cycling is enabled by defining GHOST_SCATTER_EN.
module ghost_chaser #(
    parameter logic [9:0] START_X        = 10'd200,
    parameter logic [9:0] START_Y        = 10'd200,
    parameter logic [9:0] SIZE           = 10'd4,
    parameter logic [9:0] SPEED          = 10'd1,
    parameter logic [9:0] SCATTER_X      = 10'd620,
    parameter logic [9:0] SCATTER_Y      = 10'd12,
    parameter int         CHASE_FRAMES   = 420,
    parameter int         SCATTER_FRAMES = 140
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          frame_clk,
    input  logic          respawn,
    ghost_chaser_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SAMPLE, DECIDE, MOVE} state_t;

    localparam int CNT_MAX = (CHASE_FRAMES > SCATTER_FRAMES) ? CHASE_FRAMES : SCATTER_FRAMES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CHASE_LAST   = CW'(CHASE_FRAMES - 1);
    localparam logic [CW-1:0] SCATTER_LAST = CW'(SCATTER_FRAMES - 1);

    state_t      state;
    logic        sync1, sync2, sync3;
    logic        tick;
    logic [3:0]  walls_q;
    logic [9:0]  tgt_x, tgt_y;
    logic [1:0]  next_dir;
    logic        can_move;
    logic        mode_r;
    logic        waive_rev;

`ifdef GHOST_SCATTER_EN
    logic [CW-1:0] frame_cnt;
`else
    logic unused_cfg;
    assign unused_cfg = ^{CHASE_LAST, SCATTER_LAST};
    assign mode_r     = 1'b0;
    assign waive_rev  = 1'b0;
`endif

    assign tick      = sync2 & ~sync3;
    assign bus.gSize = SIZE;
    assign bus.mode  = mode_r;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= frame_clk;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // Direction choice from the sampled walls/target; codes 0 up, 1 right, 2 down, 3 left.
    logic signed [10:0] dx, dy;
    logic [10:0]        adx, ady;
    logic [1:0]         cand [5];
    logic               cval [5];
    logic [1:0]         rev;
    logic [1:0]         pick;
    logic               found;
    logic               horiz;

    assign dx    = $signed({1'b0, tgt_x}) - $signed({1'b0, bus.gX});
    assign dy    = $signed({1'b0, tgt_y}) - $signed({1'b0, bus.gY});
    assign adx   = dx[10] ? 11'(-dx) : 11'(dx);
    assign ady   = dy[10] ? 11'(-dy) : 11'(dy);
    assign horiz = (adx >= ady);
    assign rev   = bus.dir ^ 2'd2;

    always_comb begin
        cand[0] = horiz ? (dx[10] ? 2'd3 : 2'd1) : (dy[10] ? 2'd0 : 2'd2);
        cval[0] = horiz ? (dx != 11'sd0) : (dy != 11'sd0);
        cand[1] = horiz ? (dy[10] ? 2'd0 : 2'd2) : (dx[10] ? 2'd3 : 2'd1);
        cval[1] = horiz ? (dy != 11'sd0) : (dx != 11'sd0);
        cand[2] = bus.dir;
        cval[2] = 1'b1;
        cand[3] = bus.dir[0] ? 2'd0 : 2'd1;
        cval[3] = 1'b1;
        cand[4] = bus.dir[0] ? 2'd2 : 2'd3;
        cval[4] = 1'b1;
        pick    = bus.dir;
        found   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (!found && cval[i] && !walls_q[cand[i]] && (waive_rev || cand[i] != rev)) begin
                pick  = cand[i];
                found = 1'b1;
            end
        end
        if (!found && !walls_q[rev]) begin
            pick  = rev;
            found = 1'b1;
        end
    end

    // Saturating step on the chosen axis; no wrap at the screen edges.
    logic [10:0] x_inc, y_inc;
    logic [9:0]  step_x, step_y;

    assign x_inc = {1'b0, bus.gX} + {1'b0, SPEED};
    assign y_inc = {1'b0, bus.gY} + {1'b0, SPEED};

    always_comb begin
        step_x = bus.gX;
        step_y = bus.gY;
        case (next_dir)
            2'd0:    step_y = (bus.gY < SPEED) ? 10'd0 : bus.gY - SPEED;
            2'd1:    step_x = (x_inc > 11'd639) ? 10'd639 : x_inc[9:0];
            2'd2:    step_y = (y_inc > 11'd479) ? 10'd479 : y_inc[9:0];
            default: step_x = (bus.gX < SPEED) ? 10'd0 : bus.gX - SPEED;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= IDLE;
            bus.gX        <= START_X;
            bus.gY        <= START_Y;
            bus.dir       <= 2'd0;
            bus.move_done <= 1'b0;
            walls_q       <= 4'd0;
            tgt_x         <= 10'd0;
            tgt_y         <= 10'd0;
            next_dir      <= 2'd0;
            can_move      <= 1'b0;
`ifdef GHOST_SCATTER_EN
            mode_r        <= 1'b0;
            waive_rev     <= 1'b0;
            frame_cnt     <= '0;
`endif
        end else if (respawn) begin
            state         <= IDLE;
            bus.gX        <= START_X;
            bus.gY        <= START_Y;
            bus.dir       <= 2'd0;
            bus.move_done <= 1'b0;
`ifdef GHOST_SCATTER_EN
            frame_cnt     <= '0;
`endif
        end else begin
            bus.move_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        state <= SAMPLE;
`ifdef GHOST_SCATTER_EN
                        if (frame_cnt == (mode_r ? SCATTER_LAST : CHASE_LAST)) begin
                            mode_r    <= ~mode_r;
                            frame_cnt <= '0;
                            waive_rev <= 1'b1;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                            waive_rev <= 1'b0;
                        end
`endif
                    end
                end
                SAMPLE: begin
                    walls_q <= {bus.wall_l, bus.wall_d, bus.wall_r, bus.wall_u};
                    tgt_x   <= mode_r ? SCATTER_X : bus.pX;
                    tgt_y   <= mode_r ? SCATTER_Y : bus.pY;
                    state   <= DECIDE;
                end
                DECIDE: begin
                    next_dir <= pick;
                    can_move <= found;
                    state    <= MOVE;
                end
                MOVE: begin
                    if (can_move) begin
                        bus.gX  <= step_x;
                        bus.gY  <= step_y;
                        bus.dir <= next_dir;
                    end
                    bus.move_done <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ghost_chaser.sv
// tb/tb_ghost_chaser.sv - directed self-checking bench for ghost_chaser
module tb_ghost_chaser;
    logic Clk = 1'b0;
    logic Reset;
    logic frame_clk;
    logic respawn_a, respawn_b;
    int   checks = 0;
    int   errors = 0;
    int   lat_a, pa, pb, idle_bad;

    ghost_chaser_if ifa ();
    ghost_chaser_if ifb ();

    ghost_chaser #(.CHASE_FRAMES(3)) u_a (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .respawn(respawn_a), .bus(ifa)
    );

    ghost_chaser #(.SPEED(10'd4)) u_b (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .respawn(respawn_b), .bus(ifb)
    );

    always #10 Clk = ~Clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_walls_a(input logic u, input logic r, input logic d, input logic l);
        ifa.wall_u = u; ifa.wall_r = r; ifa.wall_d = d; ifa.wall_l = l;
    endtask

    // One frame_clk pulse; records move_done pulses and first latency over a fixed window.
    task automatic run_frame(input bool_respawn_b);
        lat_a = 0; pa = 0; pb = 0;
        @(negedge Clk);
        frame_clk = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge Clk);
            #1;
            if (ifa.move_done) begin pa++; if (lat_a == 0) lat_a = i; end
            if (ifb.move_done) pb++;
            respawn_b = bool_respawn_b && (i == 4);
        end
        frame_clk = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1; frame_clk = 1'b0; respawn_a = 1'b0; respawn_b = 1'b0;
        ifa.pX = 10'd0; ifa.pY = 10'd0; set_walls_a(0, 0, 0, 0);
        ifb.pX = 10'd0; ifb.pY = 10'd0;
        ifb.wall_u = 0; ifb.wall_r = 0; ifb.wall_d = 0; ifb.wall_l = 0;
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;

        check("rst_gx", ifa.gX, 200);
        check("rst_gy", ifa.gY, 200);
        check("rst_dir", ifa.dir, 0);
        check("rst_mode", ifa.mode, 0);
        check("rst_done", ifa.move_done, 0);
        check("rst_gsize", ifa.gSize, 4);
        check("rst_b_gx", ifb.gX, 200);
        idle_bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge Clk); #1;
            if (ifa.gX !== 10'd200 || ifa.gY !== 10'd200 || ifa.dir !== 2'd0 ||
                ifa.mode !== 1'b0 || ifa.move_done !== 1'b0) idle_bad++;
        end
        check("idle_hold", idle_bad, 0);

        // open field, target right and slightly down
        ifa.pX = 10'd300; ifa.pY = 10'd210;
        ifb.pX = 10'd1000; ifb.pY = 10'd200;
        run_frame(0);
        check("f1_latency", lat_a, 6);
        check("f1_pulses", pa, 1);
        check("f1_gx", ifa.gX, 201);
        check("f1_gy", ifa.gY, 200);
        check("f1_dir", ifa.dir, 1);
        check("f1_b_gx", ifb.gX, 204);

        // right blocked, target up-right: secondary (up) wins
        set_walls_a(0, 1, 0, 0);
        ifa.pX = 10'd300; ifa.pY = 10'd150;
        run_frame(0);
        check("f2_gx", ifa.gX, 201);
        check("f2_gy", ifa.gY, 199);
        check("f2_dir", ifa.dir, 0);

        // boxed in: hold position and heading, still pulse once
        set_walls_a(1, 1, 1, 1);
        run_frame(0);
        check("f3_pulses", pa, 1);
        check("f3_gx", ifa.gX, 201);
        check("f3_gy", ifa.gY, 199);
        check("f3_dir", ifa.dir, 0);

        // only the reverse is open: taken as last resort
        set_walls_a(1, 1, 0, 1);
        run_frame(0);
        check("f4_dir", ifa.dir, 2);
        check("f4_gy", ifa.gY, 200);
        check("f4_b_gx", ifb.gX, 216);

        // drive the fast ghost into the right edge and past it
        set_walls_a(1, 1, 1, 1);
        for (int f = 0; f < 110; f++) run_frame(0);
        check("sat_b_gx", ifb.gX, 639);
        check("sat_b_gy", ifb.gY, 200);
        check("sat_b_dir", ifb.dir, 1);
        check("sat_b_pulse", pb, 1);
        check("sat_a_gy", ifa.gY, 200);

        // respawn while in DECIDE: back to spawn, no move_done
        run_frame(1);
        check("rsp_b_pulses", pb, 0);
        check("rsp_b_gx", ifb.gX, 200);
        check("rsp_b_gy", ifb.gY, 200);
        check("rsp_b_dir", ifb.dir, 0);
        check("rsp_a_pulses", pa, 1);

        // mode cycling after re-reset; chase target to the left
        @(posedge Clk); #1 Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        set_walls_a(0, 0, 0, 0);
        ifa.pX = 10'd100; ifa.pY = 10'd200;
        run_frame(0);
        run_frame(0);
        check("m2_mode", ifa.mode, 0);
        check("m2_gx", ifa.gX, 198);
        check("m2_dir", ifa.dir, 3);
        run_frame(0);
`ifdef GHOST_SCATTER_EN
        check("m3_mode", ifa.mode, 1);
        check("m3_dir", ifa.dir, 1);
        check("m3_gx", ifa.gX, 199);
        check("m3_gy", ifa.gY, 200);
`else
        check("m3_mode", ifa.mode, 0);
        check("m3_dir", ifa.dir, 3);
        check("m3_gx", ifa.gX, 197);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ghost_chaser.md
# ghost_chaser

Per-frame movement controller for one ghost sprite. Once per video frame it samples the wall flags for the ghost's current tile, picks a direction toward a target, and steps the ghost position. The target is Pac-Man's position, or a scatter corner when that mode is compiled in. It sits between the player-position/map-mask logic and the colour mapper, driving the ghost X/Y/size inputs consumed by rendering and collision.

## Interface
Clocking: one clock; reset is synchronous and active-high; clock port `Clk`, reset port `Reset`.

Parameters:
- START_X, 10'd200: spawn X
- START_Y, 10'd200: spawn Y
- SIZE, 10'd4: ghost half-size driven on gSize
- SPEED, 10'd1: pixels moved per accepted frame
- SCATTER_X / SCATTER_Y, 10'd620 / 10'd12: scatter target
- CHASE_FRAMES, 420: frames in chase mode
- SCATTER_FRAMES, 140: frames in scatter mode

Ports:
- Clk  in  1  system clock (50 MHz)
- Reset  in  1  synchronous active-high reset
- frame_clk  in  1  VGA vertical sync, asynchronous to Clk
- respawn  in  1  level, sampled each Clk; return ghost to spawn
- pX, pY  in  10 each  Pac-Man centre
- wall_u, wall_r, wall_d, wall_l  in  1 each  1 = blocked, from a map mask driven by gX/gY
- gX, gY  out  10 each  ghost centre
- gSize  out  10  constant SIZE
- dir  out  2  current heading: 0 up, 1 right, 2 down, 3 left
- mode  out  1  0 chase, 1 scatter
- move_done  out  1  one-cycle pulse when gX/gY update

## Operation
- frame_clk passes through a 2-flop synchronizer, then a rising-edge detector, which produces `tick`.
- FSM states: IDLE, SAMPLE, DECIDE, MOVE.
  - IDLE: on `tick`, go to SAMPLE.
  - SAMPLE: register the four wall flags and the target; go to DECIDE.
  - DECIDE: choose `next_dir`; go to MOVE.
  - MOVE: apply the step, pulse move_done, return to IDLE.
- Target selection: (pX, pY) when mode=0, (SCATTER_X, SCATTER_Y) when mode=1.
- Deltas: dx = target − gX and dy = target − gY, as 11-bit signed values.
- Primary axis is the one with the larger |d|; a tie selects horizontal. Primary direction follows the sign of that axis's delta. A zero delta leaves that axis with no candidate.
- Candidate order, taking the first that is not blocked and not the reverse of `dir`:
  1. primary
  2. secondary
  3. current dir
  4. remaining perpendicular directions, lower code first
  5. reverse of `dir`, as a last resort
- If all four directions are blocked, the position is unchanged, `dir` is unchanged, and move_done still pulses.
- Step: add or subtract SPEED on the chosen axis, saturating to X ∈ [0, 639] and Y ∈ [0, 479]. There is no wrap-around.
- Priority, highest first: Reset > respawn > FSM.
  - respawn in any state: gX=START_X, gY=START_Y, dir=0, state=IDLE, no move_done.
  - respawn clears the mode counter but leaves the synchronizer untouched.
- A `tick` that arrives outside IDLE is dropped.

## Timing
- Reset values: gX=START_X, gY=START_Y, gSize=SIZE, dir=0, mode=0, move_done=0, FSM=IDLE, mode counter=0, synchronizer flops=0.
- frame_clk rising edge → `tick` in 3 Clk cycles.
- `tick` → gX/gY/dir update and move_done high 3 cycles later (SAMPLE, DECIDE, MOVE). Total is 6 cycles from the frame_clk edge.
- Wall flags must be stable from the end of MOVE until SAMPLE. They are sampled exactly once, in SAMPLE.
- dir changes only in MOVE, or on respawn/Reset.
- gSize is constant.

## Configuration
- Macro `GHOST_SCATTER_EN`.
- Defined:
  - A frame counter increments on each accepted `tick`.
  - In mode 0, after CHASE_FRAMES ticks, mode becomes 1 and the counter clears. In mode 1, after SCATTER_FRAMES ticks, mode becomes 0 and the counter clears.
  - On a mode change, the reversal exclusion is waived for that frame's decision only.
- Undefined: no counter; mode is tied to 0 and the ghost always chases (pX, pY).

## Test plan
- Reset, then idle: gX=200, gY=200, dir=0, mode=0, move_done=0 for 100 cycles.
- No walls, pX=300, pY=210, one frame_clk edge → move_done 6 cycles after the edge, gX=201, gY=200, dir=1.
- dir=1, wall_r=1, wall_u=0, target up-right with |dy| < |dx| → dir=0, gY decreases by 1.
- All walls set, one frame → position and dir unchanged, move_done pulses once.
- gX=639 heading right, target X > 639 region, SPEED=4 → gX stays 639; respawn asserted mid-DECIDE → gX=200, gY=200, dir=0, no move_done.
- With GHOST_SCATTER_EN, CHASE_FRAMES=3: after the 3rd tick mode=1 and the next move heads toward (620, 12), reversal allowed on that frame.
